fft_stage_ctrl: RTL and testbench

FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

---
 rtl/fft_stage_ctrl_pkg.sv | 39 +++
 rtl/fft_bf_addr.sv | 60 ++++++
 rtl/fft_stage_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_fft_stage_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_stage_ctrl_pkg.sv
// Shared definitions for the in-place FFT stage controller.
// This package holds the FSM state encoding, the default configuration
// constants and small helpers for deriving widths and bank selection.
package fft_stage_ctrl_pkg;

   // Default configuration: a 32-point FFT.
   localparam int N_DEF = 32;
   localparam int R_DEF = 5;

   // Number of butterflies per stage.
   function automatic int half_of(input int n);
      return n / 2;
   endfunction

   // Width of the stage counter, which counts R-1 down to 0.
   function automatic int stage_w(input int r);
      return (r <= 2) ? 1 : $clog2(r);
   endfunction

   localparam int HALF = half_of(N_DEF);
   localparam int S_W  = stage_w(R_DEF);

   // Bank of a data index: even parity lives in bank0, odd parity in bank1.
   function automatic logic bank_of(input logic [31:0] x);
      return ^x;
   endfunction

   // Controller states.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_LAT  = 3'd2,
      ST_WAIT = 3'd3,
      ST_WR   = 3'd4,
      ST_ADV  = 3'd5,
      ST_DONE = 3'd6
   } fsm_state_e;

endpackage

// File: rtl/fft_bf_addr.sv
// Butterfly address generator (purely combinational).
// From stage s and butterfly b it forms the top index a (b with a zero
// inserted at bit s) and the bottom index a | 2^s, maps both onto the two
// parity-interleaved banks and derives the twiddle ROM index.
module fft_bf_addr
   import fft_stage_ctrl_pkg::*;
#(
   parameter int R  = 5,
   parameter int SW = 3
) (
   input  logic [SW-1:0] i_s,
   input  logic [R-2:0]  i_b,
   output logic [R-2:0]  o_m0_addr,
   output logic [R-2:0]  o_m1_addr,
   output logic          o_swap,
   output logic [R-2:0]  o_tw_addr
);

   localparam logic [SW-1:0] S_MAX = SW'(R - 1);

   logic [R-1:0]  b_ext_s;
   logic [R-1:0]  one_s;
   logic [R-1:0]  top_s;
   logic [R-1:0]  bot_s;
   logic [R-2:0]  one_lo_s;
   logic [R-2:0]  mask_lo_s;
   logic [R-2:0]  low_b_s;
   logic [SW-1:0] tw_shamt_s;
   logic          top_bank_s;
   logic          bot_bank_s;

   // Index arithmetic, bank mapping and twiddle index.
   always_comb begin
      b_ext_s    = {1'b0, i_b};
      one_s      = R'(1) << i_s;
      // In R-1 bits, 1<<(R-1) wraps to zero so the mask becomes all ones,
      // which is exactly the low-bit mask needed for the first stage.
      one_lo_s   = (R-1)'(1) << i_s;
      mask_lo_s  = one_lo_s - (R-1)'(1);
      low_b_s    = i_b & mask_lo_s;
      top_s      = (((b_ext_s >> i_s) << i_s) << 1) | {1'b0, low_b_s};
      bot_s      = top_s | one_s;
      top_bank_s = bank_of(32'(top_s));
      bot_bank_s = bank_of(32'(bot_s));
      tw_shamt_s = S_MAX - i_s;
      o_tw_addr  = low_b_s << tw_shamt_s;
      o_swap     = top_bank_s;
      if (top_bank_s == 1'b0) begin
         o_m0_addr = top_s[R-2:0];
      end else begin
         o_m0_addr = bot_s[R-2:0];
      end
      if (bot_bank_s == 1'b1) begin
         o_m1_addr = bot_s[R-2:0];
      end else begin
         o_m1_addr = top_s[R-2:0];
      end
   end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Sequencer for one in-place radix-2 DIF FFT pass over two memory banks.
// Walks stages R-1..0 and butterflies 0..N/2-1, issuing read, butterfly
// start, wait-for-result and write-back for each butterfly. All outputs
// are registered; they are decoded from the next state so that they line
// up with the state the FSM is in.
module fft_stage_ctrl
   import fft_stage_ctrl_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int R = R_DEF
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_bf_done,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_m0_r_en,
   output logic       o_m1_r_en,
   output logic       o_m0_w_en,
   output logic       o_m1_w_en,
   output logic [R-2:0] o_m0_addr,
   output logic [R-2:0] o_m1_addr,
   output logic       o_swap,
   output logic [R-2:0] o_tw_addr,
   output logic       o_bf_start
);

   localparam int HALF_N = half_of(N);
   localparam int SW     = stage_w(R);
   localparam int BW     = R - 1;
   localparam logic [SW-1:0] S_TOP  = SW'(R - 1);
   localparam logic [BW-1:0] B_LAST = BW'(HALF_N - 1);

   fsm_state_e    state_q, state_d;
   logic [SW-1:0] s_q, s_d;
   logic [BW-1:0] b_q, b_d;

   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          r_en_q, r_en_d;
   logic          w_en_q, w_en_d;
   logic          bf_start_q, bf_start_d;
   logic          swap_q, swap_d;
   logic [BW-1:0] m0_addr_q, m0_addr_d;
   logic [BW-1:0] m1_addr_q, m1_addr_d;
   logic [BW-1:0] tw_q, tw_d;

   logic [BW-1:0] nx_m0_s, nx_m1_s, nx_tw_s;
   logic          nx_swap_s;
   logic          addr_vld_s;

   // Addresses are generated for the upcoming counters so they register
   // together with the state that uses them.
   fft_bf_addr #(
      .R  (R),
      .SW (SW)
   ) u_bf_addr (
      .i_s       (s_d),
      .i_b       (b_d),
      .o_m0_addr (nx_m0_s),
      .o_m1_addr (nx_m1_s),
      .o_swap    (nx_swap_s),
      .o_tw_addr (nx_tw_s)
   );

   // Next-state and stage/butterfly counter logic.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      b_d     = b_q;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d = ST_RD;
               s_d     = S_TOP;
               b_d     = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD:   state_d = ST_LAT;
         ST_LAT:  state_d = ST_WAIT;
         ST_WAIT: begin
            if (i_bf_done) begin
               state_d = ST_WR;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WR:   state_d = ST_ADV;
         ST_ADV: begin
            if ((s_q == '0) && (b_q == B_LAST)) begin
               state_d = ST_DONE;
            end else if (b_q == B_LAST) begin
               state_d = ST_RD;
               b_d     = '0;
               s_d     = s_q - SW'(1);
            end else begin
               state_d = ST_RD;
               b_d     = b_q + BW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            s_d     = S_TOP;
            b_d     = '0;
         end
         default: begin
            state_d = ST_IDLE;
            s_d     = S_TOP;
            b_d     = '0;
         end
      endcase
   end

   // Output decode for the state being entered.
   always_comb begin
      busy_d     = (state_d != ST_IDLE);
      done_d     = (state_d == ST_DONE);
      r_en_d     = (state_d == ST_RD);
      w_en_d     = (state_d == ST_WR);
      bf_start_d = (state_d == ST_LAT);
      addr_vld_s = (state_d == ST_RD) || (state_d == ST_LAT) ||
                   (state_d == ST_WAIT) || (state_d == ST_WR);
      if (addr_vld_s) begin
         m0_addr_d = nx_m0_s;
         m1_addr_d = nx_m1_s;
         swap_d    = nx_swap_s;
         tw_d      = nx_tw_s;
      end else begin
         m0_addr_d = '0;
         m1_addr_d = '0;
         swap_d    = 1'b0;
         tw_d      = '0;
      end
   end

   // State, counters and registered outputs; reset abandons any pass.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         s_q        <= S_TOP;
         b_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         r_en_q     <= 1'b0;
         w_en_q     <= 1'b0;
         bf_start_q <= 1'b0;
         swap_q     <= 1'b0;
         m0_addr_q  <= '0;
         m1_addr_q  <= '0;
         tw_q       <= '0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         b_q        <= b_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         r_en_q     <= r_en_d;
         w_en_q     <= w_en_d;
         bf_start_q <= bf_start_d;
         swap_q     <= swap_d;
         m0_addr_q  <= m0_addr_d;
         m1_addr_q  <= m1_addr_d;
         tw_q       <= tw_d;
      end
   end

   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_m0_r_en  = r_en_q;
   assign o_m1_r_en  = r_en_q;
   assign o_m0_w_en  = w_en_q;
   assign o_m1_w_en  = w_en_q;
   assign o_bf_start = bf_start_q;
   assign o_swap     = swap_q;
   assign o_m0_addr  = m0_addr_q;
   assign o_m1_addr  = m1_addr_q;
   assign o_tw_addr  = tw_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl with N=8, R=3.
// Expected butterflies are queued when a pass is started and compared as
// the controller issues its read/latency/wait/write cycles.
module tb_fft_stage_ctrl;

   localparam int N = 8;
   localparam int R = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       i_rst = 1'b1;
   logic       i_start = 1'b0;
   logic       i_bf_done = 1'b1;
   logic       o_busy, o_done, o_m0_r_en, o_m1_r_en, o_m0_w_en, o_m1_w_en;
   logic [1:0] o_m0_addr, o_m1_addr, o_tw_addr;
   logic       o_swap, o_bf_start;

   fft_stage_ctrl #(.N(N), .R(R)) dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_start    (i_start),
      .i_bf_done  (i_bf_done),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_m0_r_en  (o_m0_r_en),
      .o_m1_r_en  (o_m1_r_en),
      .o_m0_w_en  (o_m0_w_en),
      .o_m1_w_en  (o_m1_w_en),
      .o_m0_addr  (o_m0_addr),
      .o_m1_addr  (o_m1_addr),
      .o_swap     (o_swap),
      .o_tw_addr  (o_tw_addr),
      .o_bf_start (o_bf_start)
   );

   typedef struct {
      int m0;
      int m1;
      int swap;
      int tw;
      int gap;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   // Monitor state
   bit   mon_en = 1'b0;
   int   cyc = 0;
   exp_t cur;
   bit   in_bfly = 1'b0;
   int   lat_cyc, last_wr_cyc, done_cyc;
   int   rd_cnt, wr_cnt, busy_cnt, done_cnt, ovl_cnt, bfs_cnt;
   int   rd_m0[12], rd_m1[12], rd_sw[12], rd_tw[12];

   // Stall driver state
   int   stall_idx = -1;
   int   stall_cnt = 0;
   int   drv_bfs = 0;

   function automatic int par3(input int x);
      int p = 0;
      for (int k = 0; k < 3; k++) p = p ^ ((x >> k) & 1);
      return p;
   endfunction

   function automatic int out_vec();
      return {o_busy, o_done, o_m0_r_en, o_m1_r_en, o_m0_w_en, o_m1_w_en,
              o_m0_addr, o_m1_addr, o_swap, o_tw_addr, o_bf_start};
   endfunction

   // Expected butterflies: for each stage, every index with bit s clear,
   // in ascending order, paired with its partner index | 2^s.
   task automatic push_expected(input int stall);
      int idx = 0;
      exp_t e;
      for (int s = 2; s >= 0; s--) begin
         for (int x = 0; x < N; x++) begin
            if (((x >> s) & 1) == 0) begin
               int bot = x | (1 << s);
               int pa  = par3(x);
               e.swap = pa;
               e.m0   = pa ? (bot & 3) : (x & 3);
               e.m1   = pa ? (x & 3) : (bot & 3);
               e.tw   = ((x & ((1 << s) - 1)) << (2 - s)) & 3;
               e.gap  = (idx == stall) ? 8 : 2;
               exp_q.push_back(e);
               idx++;
            end
         end
      end
   endtask

   // Butterfly-done driver: optionally holds i_bf_done low for 7 cycles
   // starting at the LAT cycle of one chosen butterfly.
   always @(negedge clk) begin
      if (stall_cnt > 0) begin
         i_bf_done = 1'b0;
         stall_cnt--;
      end else if (o_bf_start) begin
         if (drv_bfs == stall_idx) begin
            i_bf_done = 1'b0;
            stall_cnt = 6;
         end else begin
            i_bf_done = 1'b1;
         end
         drv_bfs++;
      end else begin
         i_bf_done = 1'b1;
      end
   end

   // Output monitor and scoreboard compare.
   always @(negedge clk) begin
      cyc++;
      if (mon_en) begin
         if (o_busy) busy_cnt++;
         if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if ((o_m0_r_en || o_m1_r_en) && (o_m0_w_en || o_m1_w_en)) ovl_cnt++;
         if (o_m0_w_en) wr_cnt++;
         if (o_m0_r_en) begin
            if (exp_q.size() == 0) begin
               chk("rd_unexpected", 1, 0);
            end else begin
               cur = exp_q.pop_front();
               in_bfly = 1'b1;
               if (rd_cnt < 12) begin
                  rd_m0[rd_cnt] = int'(o_m0_addr);
                  rd_m1[rd_cnt] = int'(o_m1_addr);
                  rd_sw[rd_cnt] = int'(o_swap);
                  rd_tw[rd_cnt] = int'(o_tw_addr);
               end
            end
            rd_cnt++;
         end
         if (in_bfly) begin
            chk("r_en_pair", int'(o_m1_r_en), int'(o_m0_r_en));
            chk("w_en_pair", int'(o_m1_w_en), int'(o_m0_w_en));
            chk("m0_addr", int'(o_m0_addr), cur.m0);
            chk("m1_addr", int'(o_m1_addr), cur.m1);
            chk("swap", int'(o_swap), cur.swap);
            chk("tw_addr", int'(o_tw_addr), cur.tw);
            if (o_bf_start) begin
               lat_cyc = cyc;
               bfs_cnt++;
            end
            if (o_m0_w_en) begin
               chk("lat_to_wr", cyc - lat_cyc, cur.gap);
               last_wr_cyc = cyc;
               in_bfly = 1'b0;
            end
         end
      end
   end

   task automatic clear_mon(input int stall);
      exp_q.delete();
      rd_cnt = 0; wr_cnt = 0; busy_cnt = 0; done_cnt = 0;
      ovl_cnt = 0; bfs_cnt = 0; in_bfly = 1'b0;
      lat_cyc = 0; last_wr_cyc = 0; done_cyc = 0;
      stall_idx = stall;
      drv_bfs = 0;
   endtask

   task automatic run_pass(input int stall, input bit mid_start);
      bit got = 1'b0;
      clear_mon(stall);
      push_expected(stall);
      mon_en = 1'b1;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (mid_start && i == 15) i_start = 1'b1;
         if (mid_start && i == 16) i_start = 1'b0;
         @(negedge clk);
         if (o_done) begin
            got = 1'b1;
            break;
         end
      end
      i_start = 1'b0;
      chk("done_seen", int'(got), 1);
      repeat (2) @(negedge clk);
      chk("rd_count", rd_cnt, 12);
      chk("wr_count", wr_cnt, 12);
      chk("bf_start_count", bfs_cnt, 12);
      chk("busy_cycles", busy_cnt, (stall >= 0) ? 67 : 61);
      chk("done_pulses", done_cnt, 1);
      chk("done_after_adv", done_cyc - last_wr_cyc, 2);
      chk("rd_wr_overlap", ovl_cnt, 0);
      chk("queue_left", exp_q.size(), 0);
      chk("idle_after_pass", out_vec(), 0);
      mon_en = 1'b0;
   endtask

   initial begin
      int wrs;
      bit hit;
      i_rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs", out_vec(), 0);
      i_rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_no_start", out_vec(), 0);

      // Nominal pass with spot checks of known butterflies.
      run_pass(-1, 1'b0);
      chk("s2b0_m0", rd_m0[0], 0);
      chk("s2b0_m1", rd_m1[0], 0);
      chk("s2b0_swap", rd_sw[0], 0);
      chk("s2b0_tw", rd_tw[0], 0);
      chk("s2b3_m0", rd_m0[3], 3);
      chk("s2b3_m1", rd_m1[3], 3);
      chk("s2b3_swap", rd_sw[3], 0);
      chk("s2b3_tw", rd_tw[3], 3);
      chk("s0b1_m0", rd_m0[9], 3);
      chk("s0b1_m1", rd_m1[9], 2);
      chk("s0b1_swap", rd_sw[9], 1);
      chk("s0b1_tw", rd_tw[9], 0);
      chk("s1b1_tw", rd_tw[5], 2);

      // Stretched WAIT on butterfly 5.
      run_pass(5, 1'b0);

      // Start pulse during a pass must be ignored.
      run_pass(-1, 1'b1);

      // Reset during a stage-1 write, with start held high alongside reset.
      clear_mon(-1);
      push_expected(-1);
      mon_en = 1'b1;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      wrs = 0;
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (o_m0_w_en) wrs++;
         if (o_m0_w_en && wrs == 6) begin
            hit = 1'b1;
            break;
         end
      end
      chk("reached_stage1_wr", int'(hit), 1);
      mon_en = 1'b0;
      i_rst = 1'b1;
      i_start = 1'b1;
      @(negedge clk);
      chk("mid_reset_outputs", out_vec(), 0);
      i_rst = 1'b0;
      i_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("start_with_reset_ignored", out_vec(), 0);

      // Fresh pass after the abandoned one restarts at s=2, b=0.
      run_pass(-1, 1'b0);
      chk("restart_m0", rd_m0[0], 0);
      chk("restart_m1", rd_m1[0], 0);
      chk("restart_tw", rd_tw[0], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
